// File: rtl/riscv_ram_sdp_pkg.sv
// Shared types, constants and helpers for the simple dual-port RAM.
package riscv_ram_pkg;

  // Controller state: clearing the array, or serving traffic.
  typedef enum logic [0:0] {
    RAM_INIT  = 1'b0,
    RAM_READY = 1'b1
  } ram_state_e;

  // Legal read latency range in cycles.
  localparam int RAM_LAT_MIN = 1;
  localparam int RAM_LAT_MAX = 2;

  // Widest word byte_merge can handle; callers cast to and from this width.
  localparam int RAM_MAX_DW = 256;

  // Replace the bytes of old_word whose strobe bit is set with bytes of new_word.
  function automatic logic [RAM_MAX_DW-1:0] byte_merge(
    input logic [RAM_MAX_DW-1:0]   old_word,
    input logic [RAM_MAX_DW-1:0]   new_word,
    input logic [RAM_MAX_DW/8-1:0] strb
  );
    logic [RAM_MAX_DW-1:0] res;
    res = old_word;
    for (int i = 0; i < RAM_MAX_DW / 8; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/riscv_ram_sdp_if.sv
// Write/read port bundle between the LSU/cache controller and the RAM.
interface riscv_ram_sdp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) ();

  logic                    init_busy;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;

  // Requester side.
  modport master (
    output wr_en, wr_addr, wr_strb, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy
  );

  // RAM side.
  modport slave (
    input  wr_en, wr_addr, wr_strb, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy
  );

endinterface

// File: rtl/riscv_ram_sdp_rd_pipe.sv
// Read-return pipeline: one or two register stages carrying valid and data.
// Data registers load only with a valid beat so rd_data holds between reads.
module riscv_ram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_data_q;

  // Stage 1: capture the word at the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        s1_data_q <= data_i;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    // Stage 2: extra output register, loaded only from a valid stage 1.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign rd_valid_o = s2_valid_q;
    assign rd_data_o  = s2_data_q;
  end else begin : g_lat1
    assign rd_valid_o = s1_valid_q;
    assign rd_data_o  = s1_data_q;
  end

endmodule

// File: rtl/riscv_ram_sdp.sv
// Simple dual-port RAM with byte strobes, 1/2-cycle read latency,
// selectable read-during-write policy and optional post-reset clear.
module riscv_ram_sdp
  import riscv_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_FIRST    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst,
  riscv_ram_sdp_if.slave ram
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam ram_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? RAM_INIT : RAM_READY;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > RAM_MAX_DW ||
      READ_LATENCY < RAM_LAT_MIN || READ_LATENCY > RAM_LAT_MAX) begin : g_param_check
    $fatal(1, "riscv_ram_sdp: illegal DATA_WIDTH or READ_LATENCY");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  logic                  ready;
  logic                  rd_fire;
  logic                  collision;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NUM_BYTES-1:0]  lane_we;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_word_d;

  assign ready         = (state_q == RAM_READY);
  assign ram.init_busy = ~ready;
  assign rd_fire       = ready & ram.rd_en;
  assign collision     = rd_fire & ram.wr_en & (ram.rd_addr == ram.wr_addr);

  // While clearing, the sequencer owns the write port and writes zeros.
  assign mem_waddr = ready ? ram.wr_addr : clr_cnt_q;
  assign mem_wdata = ready ? ram.wr_data : '0;

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane_we
    assign lane_we[gi] = ready ? (ram.wr_en & ram.wr_strb[gi]) : 1'b1;
  end

  // Old word from the array; on a write-first collision, patch in the new bytes.
  assign rd_word     = mem[ram.rd_addr];
  assign merged_word = DATA_WIDTH'(byte_merge(RAM_MAX_DW'(rd_word),
                                              RAM_MAX_DW'(ram.wr_data),
                                              (RAM_MAX_DW/8)'(ram.wr_strb)));
  assign rd_word_d   = ((WRITE_FIRST != 0) && collision) ? merged_word : rd_word;

  // Byte-lane array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (lane_we[i]) begin
        mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Next-state logic: walk the clear counter across every address once.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == RAM_INIT) begin
      clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = RAM_READY;
      end
    end
  end

  // Controller state and clear counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  riscv_ram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (rd_fire),
    .data_i    (rd_word_d),
    .rd_valid_o(ram.rd_valid),
    .rd_data_o (ram.rd_data)
  );

endmodule

// File: tb/tb_riscv_ram_sdp.sv
// Directed bench for riscv_ram_sdp: three instances share one stimulus stream.
//   u_a: latency 1, write-first, clear on reset
//   u_b: latency 2, read-first,  clear on reset
//   u_c: latency 1, write-first, no clear
module tb_riscv_ram_sdp;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_strb;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;

  int n_checks;
  int n_errors;

  riscv_ram_sdp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if_a ();
  riscv_ram_sdp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if_b ();
  riscv_ram_sdp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if_c ();

  assign if_a.wr_en = wr_en;   assign if_b.wr_en = wr_en;   assign if_c.wr_en = wr_en;
  assign if_a.wr_addr = wr_addr; assign if_b.wr_addr = wr_addr; assign if_c.wr_addr = wr_addr;
  assign if_a.wr_strb = wr_strb; assign if_b.wr_strb = wr_strb; assign if_c.wr_strb = wr_strb;
  assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data; assign if_c.wr_data = wr_data;
  assign if_a.rd_en = rd_en;   assign if_b.rd_en = rd_en;   assign if_c.rd_en = rd_en;
  assign if_a.rd_addr = rd_addr; assign if_b.rd_addr = rd_addr; assign if_c.rd_addr = rd_addr;

  riscv_ram_sdp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1),
                  .WRITE_FIRST(1), .CLEAR_ON_RESET(1))
    u_a (.clk(clk), .rst(rst), .ram(if_a));
  riscv_ram_sdp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2),
                  .WRITE_FIRST(0), .CLEAR_ON_RESET(1))
    u_b (.clk(clk), .rst(rst), .ram(if_b));
  riscv_ram_sdp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1),
                  .WRITE_FIRST(1), .CLEAR_ON_RESET(0))
    u_c (.clk(clk), .rst(rst), .ram(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the run is a fixed number of cycles, so this never fires normally.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s %h", tag, got);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_strb = strb;
    tick();
    wr_en = 1'b0;
  endtask

  // Single read: u_a answers after one edge, u_b after two.
  task automatic read_check(input string tag, input logic [3:0] addr,
                            input logic [31:0] exp_a, input logic [31:0] exp_b);
    rd_en = 1'b1; rd_addr = addr;
    tick();
    rd_en = 1'b0;
    check({tag, "_a_vld"}, 32'(if_a.rd_valid), 32'd1);
    check({tag, "_a"}, if_a.rd_data, exp_a);
    check({tag, "_b_vld0"}, 32'(if_b.rd_valid), 32'd0);
    tick();
    check({tag, "_a_vld0"}, 32'(if_a.rd_valid), 32'd0);
    check({tag, "_b_vld"}, 32'(if_b.rd_valid), 32'd1);
    check({tag, "_b"}, if_b.rd_data, exp_b);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_strb = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    tick();
    tick();

    // Reset state
    check("rst_a_vld", 32'(if_a.rd_valid), 32'd0);
    check("rst_a_data", if_a.rd_data, 32'd0);
    check("rst_b_data", if_b.rd_data, 32'd0);
    check("rst_a_busy", 32'(if_a.init_busy), 32'd1);
    check("rst_c_busy", 32'(if_c.init_busy), 32'd0);

    // Clear sequence: 16 cycles busy; no-clear instance usable immediately
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b0; rd_en = 1'b0;
      if (i == 1) begin
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h5A5A5A5A; wr_strb = 4'hF;
      end
      if (i == 2) begin
        rd_en = 1'b1; rd_addr = 4'd15;
      end
      if (i == 10) begin
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
      end
      tick();
      check($sformatf("clr_a_busy_%0d", i), 32'(if_a.init_busy), (i < 16) ? 32'd1 : 32'd0);
      if (i == 1) check("noclr_c_busy", 32'(if_c.init_busy), 32'd0);
      if (i == 2) begin
        check("noclr_c_vld", 32'(if_c.rd_valid), 32'd1);
        check("noclr_c_data", if_c.rd_data, 32'h5A5A5A5A);
        check("init_a_rd_ignored", 32'(if_a.rd_valid), 32'd0);
      end
      if (i == 16) check("clr_b_busy_16", 32'(if_b.init_busy), 32'd0);
    end
    wr_en = 1'b0; rd_en = 1'b0;

    read_check("clr3", 4'd3, 32'h0, 32'h0);
    read_check("clr9", 4'd9, 32'h0, 32'h0);

    // Byte strobes
    write(4'd5, 32'hAABBCCDD, 4'b1111);
    write(4'd5, 32'h11223344, 4'b0101);
    read_check("strb", 4'd5, 32'hAA22CC44, 32'hAA22CC44);
    write(4'd5, 32'hFFFFFFFF, 4'b0000);
    read_check("strb0", 4'd5, 32'hAA22CC44, 32'hAA22CC44);

    // Back-to-back reads, both latencies
    write(4'd0, 32'h10, 4'hF);
    write(4'd1, 32'h11, 4'hF);
    write(4'd2, 32'h12, 4'hF);
    for (int k = 1; k <= 5; k++) begin
      rd_en = (k <= 3);
      rd_addr = 4'(k - 1);
      tick();
      check($sformatf("b2b_a_vld_%0d", k), 32'(if_a.rd_valid), (k <= 3) ? 32'd1 : 32'd0);
      if (k <= 3) check($sformatf("b2b_a_%0d", k), if_a.rd_data, 32'h10 + 32'(k - 1));
      if (k == 4) check("b2b_a_hold", if_a.rd_data, 32'h12);
      check($sformatf("b2b_b_vld_%0d", k), 32'(if_b.rd_valid),
            (k >= 2 && k <= 4) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 4) check($sformatf("b2b_b_%0d", k), if_b.rd_data, 32'h10 + 32'(k - 2));
    end
    rd_en = 1'b0;

    // Collision: write-first (u_a) vs read-first (u_b)
    write(4'd7, 32'hFFFFFFFF, 4'hF);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h00000000; wr_strb = 4'b0011;
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("coll_a", if_a.rd_data, 32'hFFFF0000);
    tick();
    check("coll_b_vld", 32'(if_b.rd_valid), 32'd1);
    check("coll_b", if_b.rd_data, 32'hFFFFFFFF);
    read_check("coll_after", 4'd7, 32'hFFFF0000, 32'hFFFF0000);

    // Reset with a latency-2 read in flight
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    rd_en = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_b_vld", 32'(if_b.rd_valid), 32'd0);
    check("midrst_b_data", if_b.rd_data, 32'h0);
    check("midrst_b_busy", 32'(if_b.init_busy), 32'd1);
    check("midrst_a_vld", 32'(if_a.rd_valid), 32'd0);
    tick();
    check("midrst_b_vld_hold", 32'(if_b.rd_valid), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (if_b.rd_valid !== 1'b0) check($sformatf("reclr_b_vld_%0d", i), 32'(if_b.rd_valid), 32'd0);
      if (i >= 15) check($sformatf("reclr_b_busy_%0d", i), 32'(if_b.init_busy),
                         (i < 16) ? 32'd1 : 32'd0);
    end
    read_check("reclr5", 4'd5, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
